// File: rtl/bpu_pkg.sv
// Shared BPU definitions: 2-bit counter states, saturating update, prediction error types.
// Latency: n/a (package only).
// Backpressure: n/a.
package bpu_pkg;

   // 2-bit saturating counter states; the MSB is the taken prediction.
   localparam logic [1:0] STRONG_NT = 2'b00;
   localparam logic [1:0] WEAK_NT   = 2'b01;
   localparam logic [1:0] WEAK_T    = 2'b10;
   localparam logic [1:0] STRONG_T  = 2'b11;

   // Prediction error type, named predicted_actual; shared with the BTB and hazard unit.
   typedef enum logic [1:0] {
      Taken_Taken   = 2'b00,
      NTaken_NTaken = 2'b01,
      NTaken_Taken  = 2'b10,
      Taken_NTaken  = 2'b11
   } pred_err_e;

   // Next counter value: step toward the resolved outcome, holding at either end.
   function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      nxt = cnt;
      if (taken) begin
         if (cnt != STRONG_T) nxt = cnt + 2'd1;
      end else begin
         if (cnt != STRONG_NT) nxt = cnt - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bpu_sat_counter32.sv
// 32-bit event counter with synchronous clear, saturating at all-ones instead of wrapping.
// Latency: count reflects an inc one clock after it is sampled.
// Backpressure: none; inc is sampled every cycle.
module bpu_sat_counter32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        inc,
   output logic [31:0] count
);

   // Count up on inc, hold at the ceiling, clear on reset or clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/bht_predictor.sv
// 2-bit saturating-counter branch history table; BPU_STATS_EN adds branch/mispredict counters.
// Latency: prediction and mispredict are combinational; training lands at the next posedge clk.
// Backpressure: none; every cycle is read, and trained whenever is_branch is high.
module bht_predictor
   import bpu_pkg::*;
#(
   parameter int         BHT_INDEX_LEN = 12,
   parameter logic [1:0] CNT_INIT      = 2'b01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PCF,
   input  logic [31:0] PCE,
   input  logic        btb_hit,
   input  logic        is_branch,
   input  logic        is_taken_ex,
   input  logic        is_taken_if,
   output logic        predict_taken,
   output logic [1:0]  predict_cnt,
   output logic        mispredict
`ifdef BPU_STATS_EN
   ,
   output logic [31:0] stat_branch_cnt,
   output logic [31:0] stat_mispred_cnt
`endif
);

   localparam int DEPTH = 1 << BHT_INDEX_LEN;

   logic [1:0]               bht_table [DEPTH];
   logic [BHT_INDEX_LEN-1:0] idx_if;
   logic [BHT_INDEX_LEN-1:0] idx_ex;

   // Untagged table: upper PC bits are deliberately ignored (aliasing accepted).
   logic unused_pc_bits;
   assign unused_pc_bits = ^{PCF[31:BHT_INDEX_LEN], PCE[31:BHT_INDEX_LEN]};

   assign idx_if = PCF[BHT_INDEX_LEN-1:0];
   assign idx_ex = PCE[BHT_INDEX_LEN-1:0];

   // Read port: raw counter plus prediction; a BTB miss never predicts taken.
   // No write bypass, so a same-index update is seen only from the next cycle.
   always_comb begin
      predict_cnt   = bht_table[idx_if];
      predict_taken = btb_hit & bht_table[idx_if][1];
   end

   // Same-cycle mispredict for the hazard unit; quiet when no branch resolves.
   always_comb begin
      mispredict = is_branch & (is_taken_ex ^ is_taken_if);
   end

   // Train the EX-indexed counter on every resolved branch, regardless of BTB hit.
   // Reset initialises every entry and overrides any write in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            bht_table[i] <= CNT_INIT;
         end
      end else if (is_branch) begin
         bht_table[idx_ex] <= sat2_next(bht_table[idx_ex], is_taken_ex);
      end
   end

`ifdef BPU_STATS_EN
   bpu_sat_counter32 u_branch_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (1'b0),
      .inc   (is_branch),
      .count (stat_branch_cnt)
   );

   bpu_sat_counter32 u_mispred_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (1'b0),
      .inc   (mispredict),
      .count (stat_mispred_cnt)
   );
`endif

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: behavioural counter-table model checked every cycle, plus literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_bht_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] PCF;
   logic [31:0] PCE;
   logic        btb_hit;
   logic        is_branch;
   logic        is_taken_ex;
   logic        is_taken_if;
   logic        predict_taken;
   logic [1:0]  predict_cnt;
   logic        mispredict;
`ifdef BPU_STATS_EN
   logic [31:0] stat_branch_cnt;
   logic [31:0] stat_mispred_cnt;
`endif

   int errors = 0;
   int checks = 0;
   bit run    = 0;

   // Model state: plain integer counters per index, and event tallies.
   int model_cnt [4096];
   int model_br;
   int model_mp;

   bht_predictor dut (
      .clk           (clk),
      .rst           (rst),
      .PCF           (PCF),
      .PCE           (PCE),
      .btb_hit       (btb_hit),
      .is_branch     (is_branch),
      .is_taken_ex   (is_taken_ex),
      .is_taken_if   (is_taken_if),
      .predict_taken (predict_taken),
      .predict_cnt   (predict_cnt),
      .mispredict    (mispredict)
`ifdef BPU_STATS_EN
      ,
      .stat_branch_cnt  (stat_branch_cnt),
      .stat_mispred_cnt (stat_mispred_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a taken outcome moves the counter up by one (max 3), not-taken down by one (min 0).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4096; i++) model_cnt[i] <= 1;
         model_br <= 0;
         model_mp <= 0;
      end else if (is_branch) begin
         if (is_taken_ex) model_cnt[PCE[11:0]] <= (model_cnt[PCE[11:0]] >= 3) ? 3 : model_cnt[PCE[11:0]] + 1;
         else             model_cnt[PCE[11:0]] <= (model_cnt[PCE[11:0]] <= 0) ? 0 : model_cnt[PCE[11:0]] - 1;
         model_br <= model_br + 1;
         if (is_taken_ex != is_taken_if) model_mp <= model_mp + 1;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (run) begin
         chk("model_cnt", {30'd0, predict_cnt}, model_cnt[PCF[11:0]]);
         chk("model_taken", {31'd0, predict_taken}, (btb_hit && model_cnt[PCF[11:0]] >= 2) ? 1 : 0);
         chk("model_mispred", {31'd0, mispredict}, (is_branch && (is_taken_ex != is_taken_if)) ? 1 : 0);
`ifdef BPU_STATS_EN
         chk("model_stat_br", stat_branch_cnt, model_br);
         chk("model_stat_mp", stat_mispred_cnt, model_mp);
`endif
      end
   end

   // Drive one cycle's inputs just after posedge, return at negedge (pre-update view).
   task automatic apply(input logic [31:0] pcf, input logic [31:0] pce, input logic hit,
                        input logic br, input logic tex, input logic tif);
      @(posedge clk);
      #1;
      PCF = pcf; PCE = pce; btb_hit = hit;
      is_branch = br; is_taken_ex = tex; is_taken_if = tif;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      PCF = 32'h10; PCE = 32'h0; btb_hit = 1'b1;
      is_branch = 1'b0; is_taken_ex = 1'b0; is_taken_if = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_cnt", {30'd0, predict_cnt}, 32'h1);
      chk("reset_taken", {31'd0, predict_taken}, 32'h0);
      run = 1'b1;
      rst = 1'b0;

      // Three taken updates at 0x10: observe 01 (pre), 10, 11, 11.
      apply(32'h10, 32'h10, 1, 1, 1, 0);
      chk("tk1_pre", {30'd0, predict_cnt}, 32'h1);
      apply(32'h10, 32'h10, 1, 1, 1, 1);
      chk("tk2_cnt", {30'd0, predict_cnt}, 32'h2);
      apply(32'h10, 32'h10, 1, 1, 1, 1);
      chk("tk3_cnt", {30'd0, predict_cnt}, 32'h3);
      apply(32'h10, 32'h0, 1, 0, 0, 0);
      chk("sat_hi_cnt", {30'd0, predict_cnt}, 32'h3);
      chk("hit_taken", {31'd0, predict_taken}, 32'h1);
      apply(32'h10, 32'h0, 0, 0, 0, 0);
      chk("miss_taken", {31'd0, predict_taken}, 32'h0);

      // Not-taken walk down from 11 to saturation at 00.
      apply(32'h10, 32'h10, 1, 1, 0, 1);
      apply(32'h10, 32'h10, 1, 1, 0, 1);
      chk("nt_weak_t", {30'd0, predict_cnt}, 32'h2);
      chk("nt_weak_t_pred", {31'd0, predict_taken}, 32'h1);
      apply(32'h10, 32'h10, 1, 1, 0, 1);
      chk("nt_weak_nt", {30'd0, predict_cnt}, 32'h1);
      chk("nt_weak_nt_pred", {31'd0, predict_taken}, 32'h0);
      repeat (3) apply(32'h10, 32'h10, 1, 1, 0, 0);
      apply(32'h10, 32'h0, 1, 0, 0, 0);
      chk("sat_lo_cnt", {30'd0, predict_cnt}, 32'h0);

      // Same-index read/write: pre-update value this cycle, new value next.
      apply(32'h20, 32'h20, 1, 1, 1, 1);
      chk("rw_same_pre", {30'd0, predict_cnt}, 32'h1);
      chk("rw_no_mispred", {31'd0, mispredict}, 32'h0);
      apply(32'h20, 32'h0, 1, 0, 0, 0);
      chk("rw_same_post", {30'd0, predict_cnt}, 32'h2);
      apply(32'h1020, 32'h0, 1, 0, 0, 0);
      chk("alias_cnt", {30'd0, predict_cnt}, 32'h2);

      // Mispredict flag, and no training without is_branch.
      apply(32'h30, 32'h30, 0, 1, 0, 1);
      chk("mp_flag", {31'd0, mispredict}, 32'h1);
      apply(32'h40, 32'h40, 1, 0, 0, 1);
      chk("mp_nobranch", {31'd0, mispredict}, 32'h0);
      apply(32'h40, 32'h40, 1, 0, 1, 0);
      chk("nobranch_hold", {30'd0, predict_cnt}, 32'h1);

      // Mixed traffic across a few neighbouring indices, model-checked each cycle.
      for (int i = 0; i < 16; i++) begin
         apply(32'h100 + 32'((i + 1) % 4) * 4, 32'h100 + 32'(i % 4) * 4, 1'(i % 2),
               1'((i % 5) != 0), 1'((i % 3) != 0), 1'(i % 2));
      end

      // Asynchronous reset in the middle of a training cycle.
      apply(32'h20, 32'h20, 1, 1, 1, 1);
      chk("pre_rst_cnt", {30'd0, predict_cnt}, 32'h2);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_cnt", {30'd0, predict_cnt}, 32'h1);
      chk("midrst_taken", {31'd0, predict_taken}, 32'h0);
      @(posedge clk);
      #1;
      is_branch = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      apply(32'h10, 32'h0, 1, 0, 0, 0);
      chk("postrst_cnt", {30'd0, predict_cnt}, 32'h1);

`ifdef BPU_STATS_EN
      // Five branches, two of them mispredicted.
      apply(32'h50, 32'h50, 1, 1, 1, 1);
      apply(32'h50, 32'h50, 1, 1, 1, 0);
      apply(32'h50, 32'h50, 1, 1, 1, 1);
      apply(32'h50, 32'h50, 1, 1, 1, 1);
      apply(32'h50, 32'h50, 1, 1, 1, 0);
      apply(32'h50, 32'h0, 1, 0, 0, 0);
      chk("stat_br5", stat_branch_cnt, 32'd5);
      chk("stat_mp2", stat_mispred_cnt, 32'd2);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("stat_br_rst", stat_branch_cnt, 32'd0);
      chk("stat_mp_rst", stat_mispred_cnt, 32'd0);
      chk("stat_tbl_rst", {30'd0, predict_cnt}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
`endif

      apply(32'h0, 32'h0, 0, 0, 0, 0);
      run = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- 2-bit saturating-counter branch history table in the BPU.
- Consumes the BTB hit for the IF-stage PC and produces the final IF-stage taken/not-taken prediction for next-PC selection.
- Trained by the EX-stage branch outcome on the same cycle as the BTB update.
- Indexed by low PC bits, like the BTB; no tag (aliasing accepted).

Parameters:
- BHT_INDEX_LEN, default 12: index width; table depth = 1 << BHT_INDEX_LEN.
- CNT_INIT, default 2'b01: counter value after reset (weakly not-taken).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- PCF  input  32  IF-stage PC
- PCE  input  32  EX-stage PC
- btb_hit  input  1  BTB valid+tag hit for PCF
- is_branch  input  1  EX instruction is a conditional branch
- is_taken_ex  input  1  EX-resolved branch outcome
- is_taken_if  input  1  prediction made for this branch in IF, carried to EX
- predict_taken  output  1  final IF prediction
- predict_cnt  output  2  raw counter at the IF index
- mispredict  output  1  EX-stage mispredict flag (combinational)

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Indexing:
  - idx_if = PCF[BHT_INDEX_LEN-1:0].
  - idx_ex = PCE[BHT_INDEX_LEN-1:0].
- Read path (combinational, zero latency):
  - predict_cnt = table[idx_if].
  - predict_taken = btb_hit & table[idx_if][1].
  - BTB miss always predicts not-taken, whatever the counter value.
- Update (posedge clk, only when is_branch=1):
  - is_taken_ex=1: counter increments, saturating at 2'b11.
  - is_taken_ex=0: counter decrements, saturating at 2'b00.
  - is_branch=0: table unchanged.
- Update is independent of btb_hit and is_taken_if. The counter trains even when the BTB holds no entry.
- Counter encoding:
  - 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Prediction bit = MSB.
- mispredict = is_branch & (is_taken_ex ^ is_taken_if). Combinational, valid in the same cycle, for the hazard unit. 0 when is_branch=0.
- Same-cycle read/write to the same index (idx_if == idx_ex with is_branch=1):
  - Read returns the pre-update value (no bypass).
  - The new value is visible from the next cycle.
- Reset:
  - Async assert sets every entry to CNT_INIT.
  - predict_taken reads 0; predict_cnt reads CNT_INIT for any PCF.
  - mispredict is purely combinational and is not reset-forced.
  - Reset mid-update: reset wins; no partial write survives.
- X-safety: no output depends on uninitialised storage after reset.

Optional Feature:
- Macro BPU_STATS_EN.
- When defined, adds outputs:
  - stat_branch_cnt (32): number of cycles with is_branch=1.
  - stat_mispred_cnt (32): number of cycles with mispredict=1.
- Both counters:
  - Clear on rst.
  - Increment at posedge clk.
  - Saturate at 32'hFFFF_FFFF (no wrap).
- When not defined: ports absent, no counter flops, table behaviour identical.

Decomposition:
- Shared package bpu_pkg holds:
  - Counter localparams STRONG_NT / WEAK_NT / WEAK_T / STRONG_T.
  - The sat2_next(cnt, taken) function.
  - The 2-bit prediction error-type encodings: Taken_NTaken=11, NTaken_Taken=10, NTaken_NTaken=01, Taken_Taken=00.
- These are shared with the BTB and the hazard unit.
- One sub-module, bpu_sat_counter32 (clear, inc, saturating count), instantiated twice under BPU_STATS_EN.
- No other sub-module.

Test Plan:
1. Reset then PCF=0x0000_0010, btb_hit=1 -> predict_cnt=01, predict_taken=0.
2. PCE=0x0000_0010, is_branch=1, is_taken_ex=1 for 3 cycles -> counter goes 10, 11, 11. PCF=0x0000_0010 with btb_hit=1 gives predict_taken=1; with btb_hit=0 gives predict_taken=0.
3. From 11, two not-taken updates -> 10 (predict_taken=1), then 01 (predict_taken=0). Four more -> saturates at 00.
4. PCF=PCE=0x0000_0020, is_branch=1, taken, counter 01 -> predict_cnt=01 in that cycle, 10 next cycle.
5. is_branch=1, is_taken_ex=0, is_taken_if=1 -> mispredict=1 same cycle. is_branch=0 with the same taken values -> mispredict=0 and no counter change.
6. BPU_STATS_EN: 5 branches, 2 of them mispredicted -> stat_branch_cnt=5, stat_mispred_cnt=2. Assert rst mid-run -> both read 0 immediately and the table returns to 01.
